// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple subtract chains.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, keeping the difference only when it is non-negative.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   remainder,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_remainder,
    output logic             quotient_bit
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_sub
        full_adder u_fa (
            .a    (remainder[i]),
            .b    (~divisor[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    // A set top bit means the shifted remainder already exceeds any WIDTH-bit divisor.
    assign quotient_bit   = remainder[WIDTH] | carry[WIDTH];
    assign next_remainder = quotient_bit ? diff : remainder[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Data_in_Start,
    input  logic [WIDTH-1:0] Data_in_Dividend,
    input  logic [WIDTH-1:0] Data_in_Divisor,
    output logic [WIDTH-1:0] Data_out_Quotient,
    output logic [WIDTH-1:0] Data_out_Remainder,
    output logic             Data_out_Busy,
    output logic             Data_out_Done,
    output logic             Data_out_DivByZero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] rem_r, dvd_r, dvs_r;
    logic [CNT_W-1:0] cnt;
    logic             zero_pend;
    logic             accept_c, last_c, div_zero_c;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH-1:0] q_raw, q_fin, r_fin;

    assign div_zero_c = (Data_in_Divisor == '0);
    assign q_raw      = {dvd_r[WIDTH-2:0], step_q};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg, r_neg;

    // Divide magnitudes; MIN maps to 2^(WIDTH-1), which still fits unsigned.
    assign mag_dvd = Data_in_Dividend[WIDTH-1] ? WIDTH'(-Data_in_Dividend) : Data_in_Dividend;
    assign mag_dvs = Data_in_Divisor[WIDTH-1]  ? WIDTH'(-Data_in_Divisor)  : Data_in_Divisor;
    assign q_fin   = q_neg ? WIDTH'(-q_raw)    : q_raw;
    assign r_fin   = r_neg ? WIDTH'(-step_rem) : step_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept_c) begin
            q_neg <= Data_in_Dividend[WIDTH-1] ^ Data_in_Divisor[WIDTH-1];
            r_neg <= Data_in_Dividend[WIDTH-1];
        end
    end
`else
    assign mag_dvd = Data_in_Dividend;
    assign mag_dvs = Data_in_Divisor;
    assign q_fin   = q_raw;
    assign r_fin   = step_rem;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .remainder      ({rem_r, dvd_r[WIDTH-1]}),
        .divisor        (dvs_r),
        .next_remainder (step_rem),
        .quotient_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Divide-by-zero parks in IDLE for one cycle with zero_pend set, then reports.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (zero_pend) begin
                    state_next = DONE;
                end else if (Data_in_Start) begin
                    accept_c   = 1'b1;
                    state_next = div_zero_c ? IDLE : RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (Data_in_Start) begin
                    accept_c   = 1'b1;
                    state_next = div_zero_c ? IDLE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r              <= '0;
            dvd_r              <= '0;
            dvs_r              <= '0;
            cnt                <= '0;
            zero_pend          <= 1'b0;
            Data_out_Quotient  <= '0;
            Data_out_Remainder <= '0;
            Data_out_Busy      <= 1'b0;
            Data_out_Done      <= 1'b0;
            Data_out_DivByZero <= 1'b0;
        end else begin
            Data_out_Busy <= (state_next == RUN);
            Data_out_Done <= (state_next == DONE);
            if (accept_c) begin
                rem_r <= '0;
                dvd_r <= div_zero_c ? Data_in_Dividend : mag_dvd;
                dvs_r <= mag_dvs;
                cnt   <= div_zero_c ? '0 : CNT_W'(WIDTH);
                if (div_zero_c) zero_pend <= 1'b1;
                else            Data_out_DivByZero <= 1'b0;
            end else if (zero_pend) begin
                zero_pend          <= 1'b0;
                Data_out_Quotient  <= '1;
                Data_out_Remainder <= dvd_r;
                Data_out_DivByZero <= 1'b1;
            end else if (state == RUN) begin
                rem_r <= step_rem;
                dvd_r <= q_raw;
                cnt   <= cnt - CNT_W'(1);
                if (last_c) begin
                    Data_out_Quotient  <= q_fin;
                    Data_out_Remainder <= r_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider at WIDTH=8.
// Signed checks are added when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .Data_in_Start      (start),
        .Data_in_Dividend   (dividend),
        .Data_in_Divisor    (divisor),
        .Data_out_Quotient  (quotient),
        .Data_out_Remainder (remainder),
        .Data_out_Busy      (busy),
        .Data_out_Done      (done),
        .Data_out_DivByZero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one accepted Start edge and queue the expected result.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz;
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Wait (bounded) for Done, then check latency, Busy cycles and the popped result.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int   lat    = 0;
        int   busy_n = 0;
        exp_t e;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            tick();
            lat++;
        end
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_n), 32'(exp_busy));
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_q"}, 32'(quotient), 32'(e.q));
            check({tag, "_r"}, 32'(remainder), 32'(e.r));
            check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
        end
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        check("rst_q", 32'(quotient), 32'(0));
        check("rst_r", 32'(remainder), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_dz", 32'(div_by_zero), 32'(0));
        rst = 1'b0;
        tick();

        start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        check("run_busy", 32'(busy), 32'(1));
        wait_done("d100_7", 8, 8);
        tick();
        check("done_pulse_low", 32'(done), 32'(0));
        check("hold_q", 32'(quotient), 32'(14));
        check("hold_r", 32'(remainder), 32'(2));

        start_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        wait_done("d255_1", 8, 8);
        start_op(8'd3, 8'd200, 8'd0, 8'd3, 1'b0);
        wait_done("d3_200", 8, 8);

        start_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        check("dz_no_busy", 32'(busy), 32'(0));
        wait_done("d5_0", 1, 0);
        start_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        check("dz_cleared", 32'(div_by_zero), 32'(0));
        wait_done("d9_3", 8, 8);
        tick();

        // Start pulsed mid-run must be ignored.
        start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        tick(); tick();
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore_start", 5, 5);
        tick();
        check("ignore_idle", 32'(busy), 32'(0));

        // Reset mid-run aborts without a Done pulse.
        start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("abort_q", 32'(quotient), 32'(0));
        check("abort_r", 32'(remainder), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_dz", 32'(div_by_zero), 32'(0));
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        check("abort_no_done", 32'(done_seen), 32'(0));
        start_op(8'd20, 8'd6, 8'd3, 8'd2, 1'b0);
        wait_done("d20_6", 8, 8);

`ifdef SEQ_DIVIDER_SIGNED_EN
        start_op(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0);
        wait_done("s_m7_2", 8, 8);
        start_op(8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0);
        wait_done("s_7_m2", 8, 8);
        start_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        wait_done("s_min_m1", 8, 8);
        start_op(8'h80, 8'd0, 8'hFF, 8'h80, 1'b1);
        wait_done("s_min_0", 1, 0);
`else
        start_op(8'd200, 8'd13, 8'd15, 8'd5, 1'b0);
        wait_done("d200_13", 8, 8);
        start_op(8'd254, 8'd255, 8'd0, 8'd254, 1'b0);
        wait_done("d254_255", 8, 8);
`endif
        tick();
        check("final_idle_done", 32'(done), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
